// File: rtl/alu_seq_muldiv_if.sv
// Request/response bundle for the registered execute ALU: operand handshake in,
// result handshake plus status flags out.
interface alu_seq_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] port_a;
   logic [WIDTH-1:0] port_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_port;
   logic             zero;
   logic             overflow;
   logic             negative;
   logic             busy;

   modport master (
      output in_valid, op, port_a, port_b, out_ready,
      input  in_ready, out_valid, out_port, zero, overflow, negative, busy
   );

   modport slave (
      input  in_valid, op, port_a, port_b, out_ready,
      output in_ready, out_valid, out_port, zero, overflow, negative, busy
   );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered execute ALU with valid/ready on both sides. Single-cycle ops finish in
// one cycle; unsigned multiply/divide iterate one radix-2 step per cycle.
module alu_seq_muldiv #(
   parameter int WIDTH = 32
) (
   input logic              CLK,
   input logic              nRST,
   alu_seq_muldiv_if.slave  bus
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_e;

   typedef enum logic [3:0] {
      OP_SLL   = 4'd0,
      OP_SRL   = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_AND   = 4'd4,
      OP_OR    = 4'd5,
      OP_XOR   = 4'd6,
      OP_NOR   = 4'd7,
      OP_MULU  = 4'd8,
      OP_DIVU  = 4'd9,
      OP_SLT   = 4'd10,
      OP_SLTU  = 4'd11,
      OP_REMU  = 4'd12,
      OP_MULHU = 4'd13
   } op_e;

   state_e             state_q, state_d;
   logic [SHAMT_W-1:0] cnt_q;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   hi_q;      // product high half / partial remainder
   logic [WIDTH-1:0]   lo_q;      // multiplier being consumed / quotient being built
   logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor, constant during CALC
   logic [WIDTH-1:0]   res_q;
   logic               zero_q;
   logic               ovf_q;
   logic               neg_q;

   logic               accept;
   logic               in_ready;
   logic               in_is_iter;
   logic               in_is_mul;

   // ---------------------------------------------------------------- single-cycle ops
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   dif;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_ovf;
   logic               sc_legal;
   logic               sc_zero;
   logic               sc_neg;

   // NOTE: every signal written in an always_comb gets a default first, so no path
   // through the case statements can leave it unassigned and infer a latch.
   always_comb begin
      sum      = bus.port_a + bus.port_b;
      dif      = bus.port_a - bus.port_b;
      sc_res   = '0;
      sc_ovf   = 1'b0;
      sc_legal = 1'b1;
      case (bus.op)
         OP_SLL:  sc_res = bus.port_a << bus.port_b[SHAMT_W-1:0];
         OP_SRL:  sc_res = bus.port_a >> bus.port_b[SHAMT_W-1:0];
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (bus.port_a[WIDTH-1] == bus.port_b[WIDTH-1]) &
                     (sum[WIDTH-1] != bus.port_a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = dif;
            sc_ovf = (bus.port_a[WIDTH-1] != bus.port_b[WIDTH-1]) &
                     (dif[WIDTH-1] != bus.port_a[WIDTH-1]);
         end
         OP_AND:  sc_res = bus.port_a & bus.port_b;
         OP_OR:   sc_res = bus.port_a | bus.port_b;
         OP_XOR:  sc_res = bus.port_a ^ bus.port_b;
         OP_NOR:  sc_res = ~(bus.port_a | bus.port_b);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.port_a) < $signed(bus.port_b)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, bus.port_a < bus.port_b};
         default: sc_legal = 1'b0;
      endcase
      // SLT/SLTU leave the top bit clear and illegal ops yield 0, so the sign bit
      // alone gives the right negative flag for every single-cycle op.
      sc_neg  = sc_res[WIDTH-1];
      sc_zero = sc_legal & (sc_res == '0);
   end

   assign in_is_mul  = (bus.op == OP_MULU) | (bus.op == OP_MULHU);
   assign in_is_iter = in_is_mul | (bus.op == OP_DIVU) | (bus.op == OP_REMU);

   // ---------------------------------------------------------------- iterative step
   logic               op_is_mul;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   hi_n;
   logic [WIDTH-1:0]   lo_n;
   logic [WIDTH-1:0]   it_res;
   logic               it_ovf;

   assign op_is_mul = (op_q == OP_MULU) | (op_q == OP_MULHU);
   assign addend    = lo_q[0] ? opnd_q : '0;
   assign mul_sum   = {1'b0, hi_q} + {1'b0, addend};
   assign rem_sh    = {hi_q, lo_q[WIDTH-1]};
   assign trial     = rem_sh - {1'b0, opnd_q};

   always_comb begin
      hi_n = rem_sh[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b0};
      if (op_is_mul) begin
         // Shift-add: the carry out of the add becomes the new top product bit.
         hi_n = mul_sum[WIDTH:1];
         lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         // Restoring divide: keep the difference when it did not go negative. A zero
         // divisor always succeeds, giving all-ones quotient and remainder = dividend.
         hi_n = trial[WIDTH-1:0];
         lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      it_res = hi_n;
      it_ovf = 1'b0;
      case (op_q)
         OP_MULU: begin
            it_res = lo_n;
            it_ovf = (hi_n != '0);
         end
         OP_DIVU: begin
            it_res = lo_n;
            it_ovf = (opnd_q == '0);
         end
         OP_REMU: it_ovf = (opnd_q == '0);
         default: it_ovf = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------- control FSM
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_d = in_is_iter ? S_CALC : S_DONE;
         end
         S_CALC: begin
            if (cnt_q == LAST_STEP) state_d = S_DONE;
         end
         S_DONE: begin
            in_ready = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) state_d = in_is_iter ? S_CALC : S_DONE;
               else              state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign accept = bus.in_valid & in_ready;

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // register samples the pre-edge value of its neighbours regardless of block order.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cnt_q  <= '0;
         op_q   <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         res_q  <= '0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else if (accept) begin
         if (in_is_iter) begin
            op_q   <= bus.op;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= in_is_mul ? bus.port_b : bus.port_a;
            opnd_q <= in_is_mul ? bus.port_a : bus.port_b;
         end else begin
            res_q  <= sc_res;
            zero_q <= sc_zero;
            ovf_q  <= sc_ovf;
            neg_q  <= sc_neg;
         end
      end else if (state_q == S_CALC) begin
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         cnt_q <= cnt_q + SHAMT_W'(1);
         if (cnt_q == LAST_STEP) begin
            res_q  <= it_res;
            zero_q <= (it_res == '0);
            ovf_q  <= it_ovf;
            neg_q  <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q == S_CALC);
   assign bus.out_port  = res_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign bus.negative  = neg_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench: the driver pushes model results on accept, the monitor checks every
// presented result, its latency, busy duration and the ready/valid relationship.
module tb_alu_seq_muldiv;

   localparam int W = 32;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] res;
      logic        z;
      logic        v;
      logic        n;
      int          lat;
      int          busy;
      int          acc;
   } exp_t;

   logic clk;
   logic nrst;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   rand_ready = 0;
   bit   fixed_ready = 1;
   exp_t exp_q[$];

   alu_seq_muldiv_if #(.WIDTH(W)) bus ();

   alu_seq_muldiv #(.WIDTH(W)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on 32/64-bit values.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      e.op = op; e.res = '0; e.z = 0; e.v = 0; e.n = 0; e.lat = 1; e.busy = 0; e.acc = 0;
      p = {32'd0, a} * {32'd0, b};
      case (op)
         4'd0:  e.res = a << b[4:0];
         4'd1:  e.res = a >> b[4:0];
         4'd2:  begin e.res = a + b; e.v = (a[31] == b[31]) && (e.res[31] != a[31]); end
         4'd3:  begin e.res = a - b; e.v = (a[31] != b[31]) && (e.res[31] != a[31]); end
         4'd4:  e.res = a & b;
         4'd5:  e.res = a | b;
         4'd6:  e.res = a ^ b;
         4'd7:  e.res = ~(a | b);
         4'd8:  begin e.res = p[31:0]; e.v = (p[63:32] != 0); end
         4'd9:  begin e.res = (b == 0) ? 32'hFFFF_FFFF : a / b; e.v = (b == 0); end
         4'd10: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd11: e.res = (a < b) ? 32'd1 : 32'd0;
         4'd12: begin e.res = (b == 0) ? a : a % b; e.v = (b == 0); end
         4'd13: e.res = p[63:32];
         default: e.res = '0;
      endcase
      if (op inside {4'd8, 4'd9, 4'd12, 4'd13}) begin
         e.lat  = 33;
         e.busy = 32;
      end
      if (op <= 4'd7 || op == 4'd10) e.n = e.res[31];
      if (op <= 4'd13) e.z = (e.res == 0);
      return e;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int   guard = 0;
      exp_t e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.port_a   = a;
      bus.port_b   = b;
      #1;
      while (!bus.in_ready) begin
         guard++;
         if (guard > 200) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected accept", guard);
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         #1;
      end
      e     = model(op, a, b);
      e.acc = cyc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      // Garbage on the operand lines must not disturb an op already in flight.
      bus.in_valid = 1'b0;
      bus.op       = 4'($urandom);
      bus.port_a   = $urandom;
      bus.port_b   = $urandom;
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      check("drain_outstanding", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_busy"},      bus.busy, 0);
      check({tag, "_out_port"},  bus.out_port, 0);
      check({tag, "_zero"},      bus.zero, 0);
      check({tag, "_overflow"},  bus.overflow, 0);
      check({tag, "_negative"},  bus.negative, 0);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'($urandom_range(0, 15));
         2:       return 32'h8000_0000 | 32'($urandom_range(0, 15));
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: compares every cycle a result is presented, pops on handshake.
   initial begin
      bit   new_res = 1;
      int   busy_cnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!nrst) begin
            new_res  = 1;
            busy_cnt = 0;
         end else begin
            if (bus.busy) busy_cnt++;
            if (bus.out_valid) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_result: out_valid with out_port 0x%08h, expected no result", bus.out_port);
               end else begin
                  e = exp_q[0];
                  if (new_res) begin
                     check($sformatf("latency op%0d", e.op), cyc - e.acc, e.lat);
                     check($sformatf("busy_cycles op%0d", e.op), busy_cnt, e.busy);
                     busy_cnt = 0;
                     new_res  = 0;
                  end
                  check($sformatf("result op%0d", e.op),   bus.out_port, e.res);
                  check($sformatf("zero op%0d", e.op),     bus.zero, e.z);
                  check($sformatf("overflow op%0d", e.op), bus.overflow, e.v);
                  check($sformatf("negative op%0d", e.op), bus.negative, e.n);
                  check("in_ready_done", bus.in_ready, bus.out_ready);
                  if (bus.out_ready) begin
                     void'(exp_q.pop_front());
                     new_res = 1;
                  end
               end
            end else begin
               new_res = 1;
               if (!bus.busy) check("in_ready_idle", bus.in_ready, 1);
            end
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.op       = '0;
      bus.port_a   = '0;
      bus.port_b   = '0;
      nrst         = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #3;
      check_reset_outputs("por");
      nrst = 1'b1;

      // Signed overflow in both directions.
      issue(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
      issue(4'd2, 32'h8000_0000, 32'h8000_0000);
      issue(4'd3, 32'h8000_0000, 32'h0000_0001);
      issue(4'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF);

      // Iterative multiply and divide, including divide by zero.
      issue(4'd8,  32'h0001_0000, 32'h0001_0000);
      issue(4'd13, 32'h0001_0000, 32'h0001_0000);
      issue(4'd9,  32'd100, 32'd7);
      issue(4'd12, 32'd100, 32'd7);
      issue(4'd9,  32'd5, 32'd0);
      issue(4'd12, 32'd5, 32'd0);
      issue(4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_drain();

      // Back-to-back, then a 5-cycle stall on the result side.
      issue(4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00);
      issue(4'd5,  32'hF0F0_F0F0, 32'h0F0F_0000);
      issue(4'd10, 32'hFFFF_FFFF, 32'h0000_0001);
      fixed_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      fixed_ready = 1'b1;
      wait_drain();

      // Reset in the middle of a divide: the result must never appear.
      issue(4'd9, 32'd123456789, 32'd89);
      repeat (8) @(negedge clk);
      nrst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #3;
      check_reset_outputs("mid_calc_rst");
      @(negedge clk);
      nrst = 1'b1;
      #1;
      check("in_ready_after_rst", bus.in_ready, 1);
      repeat (40) @(negedge clk);

      // Shift amount wraps modulo the width; illegal ops give 0 with no flags.
      issue(4'd0, 32'd1, 32'd33);
      issue(4'd1, 32'h8000_0000, 32'd63);
      issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
      issue(4'd14, 32'd0, 32'd0);
      issue(4'd7, 32'd0, 32'd0);
      issue(4'd11, 32'hFFFF_FFFF, 32'd1);
      wait_drain();

      // Randomised traffic with a random consumer.
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
      end
      rand_ready  = 1'b0;
      fixed_ready = 1'b1;
      wait_drain();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
